simon_data_out: RTL
===================

// Module: simon_data_out
// PURPOSE
//  Output-side packet transmitter for the SIMON datapath; mirror of the input packet loader.
//  Buffers finished cipher blocks (2 x N-bit words plus info/count tag bytes) in a small FIFO.
//  Presents each block as one byte-array packet to the external receiver.
//  Handshake is 4-phase: outPKT / readPKT. Sits between the SIMON round core and the host interface.
// PARAMETERS
//  N      16  cipher word size in bits; multiple of 8 (packet carries 2 words = N/4 bytes)
//  DEPTH  4   FIFO depth in blocks; power of 2, >= 2
// PORTS
//  clk        in   1                single clock, all state on posedge
//  R          in   1                synchronous active-high reset
//  doneDATA   in   1                one-cycle strobe: cipher result valid this cycle
//  outDATA    in   [1:0][N-1:0]     result words, sampled with doneDATA
//  infoOUT    in   8                info/tag byte, sampled with doneDATA
//  countOUT   in   8                block count byte, sampled with doneDATA
//  readyOUT   out  1                FIFO can accept a block (occupancy < DEPTH)
//  readPKT    in   1                receiver acknowledge (4-phase)
//  outPKT     out  1                packet valid on out
//  out        out  [(1+N/4):0][7:0] packet bytes
//  donePKT    out  1                one-cycle pulse when a packet is retired
//  countSENT  out  8                packets retired since reset, wraps 255->0
//  overflow   out  1                sticky: doneDATA seen while readyOUT=0
// BEHAVIOUR
//  Reset (R=1 at posedge) clears all state:
//   - FIFO emptied, pointers 0; FSM=IDLE.
//   - outPKT=0, out='0, donePKT=0, countSENT=0, overflow=0, readyOUT=1.
//  Reset overrides every other input in the same cycle, including mid-packet; buffered blocks are discarded.
//  Packet format, fixed:
//   - out[0] = infoOUT; out[1] = countOUT.
//   - out[2+k] = byte k of {outDATA[1],outDATA[0]}, k=0 = outDATA[0][7:0] (little-endian).
//  Push: doneDATA=1 and readyOUT=1 at posedge -> block written at wr_ptr, occupancy+1.
//   - readyOUT is combinational from registered occupancy only; not from same-cycle pop.
//   - doneDATA=1 while readyOUT=0 -> block dropped, overflow<=1 (cleared only by reset).
//   - A pop on the same edge does not rescue that block.
//  FSM, 2-bit state:
//   - IDLE: FIFO non-empty -> SEND at next edge; out<=head block, outPKT<=1. readPKT ignored in IDLE.
//   - SEND: outPKT=1, out held stable.
//       readPKT=1 -> RELEASE; outPKT<=0, head popped (rd_ptr+1, occupancy-1), donePKT<=1 for one cycle,
//       countSENT<=countSENT+1 (mod 256).
//       readPKT=0 -> stay in SEND.
//   - RELEASE: outPKT=0; wait for readPKT=0, then IDLE. Held high -> remain; no new packet offered.
//   - out keeps last packet value outside SEND; it is reloaded only on IDLE->SEND.
//  Timing:
//   - Latency: doneDATA sampled at edge k into empty FIFO -> outPKT=1 after edge k+1.
//   - Minimum 3 cycles per packet (SEND, RELEASE, IDLE) with an immediate-ack receiver.
//   - Push and pop on the same edge: occupancy unchanged; data order preserved (strict FIFO).
//  Pointers: log2(DEPTH) bits with natural wrap. Occupancy counter: log2(DEPTH)+1 bits, range 0..DEPTH.
// TESTING
//  1 Reset: R=1 for 2 cycles, then R=0.
//    -> outPKT=0, readyOUT=1, out=0, donePKT=0, countSENT=0, overflow=0.
//  2 Single block (N=16): doneDATA with outDATA={16'hABCD,16'h1234}, infoOUT=8'h01, countOUT=8'h05.
//    -> outPKT=1 after 2nd edge; out = {AB,CD,12,34,05,01} (out[5]..out[0]).
//    -> readPKT=1: outPKT=0, donePKT=1 for one cycle, countSENT=1.
//  3 Overflow (DEPTH=4): readPKT=0, 5 doneDATA pulses with countOUT=0..4.
//    -> readyOUT=0 after the 4th; overflow=1.
//    -> then acking yields exactly 4 packets, out[1]=0,1,2,3 in order.
//  4 Sticky ack: hold readPKT=1 for 5 cycles during RELEASE with 2 blocks queued.
//    -> outPKT stays 0, FSM stays in RELEASE, second packet only after readPKT=0.
//  5 Full + pop same edge: FIFO full, doneDATA on the edge SEND->RELEASE pops.
//    -> block dropped, overflow=1, occupancy=3 afterwards.
//  6 Reset mid-SEND: 2 blocks queued, outPKT=1, assert R.
//    -> next cycle outPKT=0, readyOUT=1, countSENT=0; no further packets without new doneDATA.

Source files
------------

// File: rtl/simon_data_out_if.sv
// simon_data_out_if
//   Packet-side 4-phase handshake between the SIMON output transmitter and the
//   external receiver.
//   Signals:
//     outPKT   packet valid (transmitter -> receiver)
//     out      packet bytes, (2 + N/4) x 8 bits (transmitter -> receiver)
//     readPKT  receiver acknowledge (receiver -> transmitter)
//   Modports: master = transmitter, slave = receiver.
interface simon_data_out_if #(
    parameter int unsigned N = 16
);
    logic                    outPKT;
    logic                    readPKT;
    logic [(1+N/4):0][7:0]   out;

    modport master (
        output outPKT,
        output out,
        input  readPKT
    );

    modport slave (
        input  outPKT,
        input  out,
        output readPKT
    );
endinterface

// File: rtl/simon_data_out.sv
// simon_data_out
//   Output-side packet transmitter for the SIMON datapath. Finished cipher blocks
//   (two N-bit words plus info and count tag bytes) are buffered in a DEPTH-entry
//   FIFO and offered one at a time as a byte-array packet over a 4-phase
//   outPKT/readPKT handshake.
//   Ports:
//     clk        clock, all state on posedge
//     R          synchronous active-high reset, overrides everything
//     doneDATA   one-cycle strobe, cipher result valid
//     outDATA    result words [1:0][N-1:0], sampled with doneDATA
//     infoOUT    info/tag byte, sampled with doneDATA
//     countOUT   block count byte, sampled with doneDATA
//     readyOUT   FIFO can accept a block
//     pkt        packet handshake (outPKT, out, readPKT), master side
//     donePKT    one-cycle pulse when a packet is retired
//     countSENT  packets retired since reset, wraps at 256
//     overflow   sticky, a block arrived while the FIFO was full
//   Packet layout: out[0]=info, out[1]=count, out[2+k]=byte k of
//   {outDATA[1], outDATA[0]} (little-endian).
module simon_data_out #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  doneDATA,
    input  logic [1:0][N-1:0]     outDATA,
    input  logic [7:0]            infoOUT,
    input  logic [7:0]            countOUT,
    output logic                  readyOUT,
    simon_data_out_if.master      pkt,
    output logic                  donePKT,
    output logic [7:0]            countSENT,
    output logic                  overflow
);
    localparam int unsigned NB = 2 + N / 4;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [NB-1:0][7:0] packetT;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRelease
    } stateT;

    packetT          fifoMem [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [CW-1:0]   occ;

    stateT           state;
    logic            outPktQ;
    packetT          outQ;

    packetT          inBlock;
    logic            push;
    logic            pop;

    // Packed concatenation lands info in byte 0, count in byte 1 and the words
    // little-endian above them.
    assign inBlock  = {outDATA, countOUT, infoOUT};

    // Registered occupancy only, so a pop on the same edge cannot admit a block.
    assign readyOUT = (occ < CW'(DEPTH));
    assign push     = doneDATA & readyOUT;
    assign pop      = (state == StSend) & pkt.readPKT;

    assign pkt.outPKT = outPktQ;
    assign pkt.out    = outQ;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (R) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= inBlock;
                wrPtr          <= wrPtr + PW'(1);
            end
            if (doneDATA && !readyOUT) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (R) begin
            state     <= StIdle;
            outPktQ   <= 1'b0;
            outQ      <= '0;
            donePKT   <= 1'b0;
            countSENT <= 8'd0;
        end else begin
            donePKT <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (occ != '0) begin
                        outQ    <= fifoMem[rdPtr];
                        outPktQ <= 1'b1;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (pkt.readPKT) begin
                        outPktQ   <= 1'b0;
                        donePKT   <= 1'b1;
                        countSENT <= countSENT + 8'd1;
                        state     <= StRelease;
                    end
                end
                StRelease: begin
                    // Receiver must drop its acknowledge before the next packet.
                    if (!pkt.readPKT) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state   <= StIdle;
                    outPktQ <= 1'b0;
                end
            endcase
        end
    end
endmodule
